serial_adder: RTL and testbench

Multi-cycle, parametrised add/subtract unit that processes two WIDTH-bit operands CHUNK bits per clock, rippling the carry through a register between chunks. It trades latency for area and sits beside the combinational half/full adder chain as the ALU datapath option when a wide single-cycle ripple is too slow or too large. It handles operands with a valid/ready handshake on input and output. The result is held until the consumer accepts it.

---
 rtl/serial_adder_if.sv | 28 ++
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake bundle for the serial adder: operand side (in_*) and result side (out_*).
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             sub_i;
    logic             carry_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;
    logic             overflow_o;

    // The adder itself sits on this side of the bundle.
    modport slave (
        input  in_valid_i, a_i, b_i, sub_i, carry_i, out_ready_i,
        output in_ready_o, out_valid_o, sum_o, carry_o, overflow_o
    );

    // The producer/consumer of operands and results sits on this side.
    modport master (
        output in_valid_i, a_i, b_i, sub_i, carry_i, out_ready_i,
        input  in_ready_o, out_valid_o, sum_o, carry_o, overflow_o
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract unit: CHUNK bits per clock, carry rippled through a
// register between chunks. Subtraction is A + ~B + ~borrow, so the carry out
// reads as "no borrow" and no separate mode bit needs to be kept after accept.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    serial_adder_if.slave bus
);
    localparam int STEPS = WIDTH / CHUNK;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 1 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    step;
    logic             carry_reg;
    logic             carry_out_reg;
    logic             overflow_reg;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             chunk_overflow;
    logic             last_step;

    // Select the operand chunk addressed by the step counter and add it with the carry.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < STEPS; i++) begin
            if (step == CW'(i)) begin
                a_chunk = a_reg[i*CHUNK +: CHUNK];
                b_chunk = b_reg[i*CHUNK +: CHUNK];
            end
        end
        chunk_sum      = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};
        chunk_overflow = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];
        last_step      = (step == CW'(STEPS - 1));
    end

    // Control FSM and datapath registers: accept in IDLE, one chunk per cycle in RUN, hold in DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            step          <= '0;
            carry_reg     <= 1'b0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        a_reg         <= bus.a_i;
                        b_reg         <= bus.sub_i ? ~bus.b_i : bus.b_i;
                        carry_reg     <= bus.sub_i ? ~bus.carry_i : bus.carry_i;
                        step          <= '0;
                        sum_reg       <= '0;
                        carry_out_reg <= 1'b0;
                        overflow_reg  <= 1'b0;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < STEPS; i++) begin
                        if (step == CW'(i)) begin
                            sum_reg[i*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                        end
                    end
                    carry_reg <= chunk_sum[CHUNK];
                    if (last_step) begin
                        step          <= '0;
                        carry_out_reg <= chunk_sum[CHUNK];
                        overflow_reg  <= chunk_overflow;
                        state         <= DONE;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = (state == IDLE);
    assign bus.out_valid_o = (state == DONE);
    assign bus.sum_o       = sum_reg;
    assign bus.carry_o     = carry_out_reg;
    assign bus.overflow_o  = overflow_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vectors on 8/1 and 8/4 instances, then a
// randomised scoreboard regression on 8/1, 8/2, 16/4 and 32/32 instances.
module tb_serial_adder;
    localparam int NOPS       = 1000;
    localparam int RAND_LIMIT = 40000;

    typedef struct {
        int         sel;
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [7:0] esum;
        logic       ecarry;
        logic       eovf;
        int         lat;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        v;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic start_random = 1'b0;

    always #5 clk = ~clk;

    // Directed-test drive variables, shared by the two directed instances.
    logic [7:0] a, b;
    logic       sub, cin, vld, ordy;
    int         sel;
    logic [7:0] rsum;
    logic       rcarry, rovf, rvalid, rready;

    serial_adder_if #(.WIDTH(8)) d81_if ();
    serial_adder_if #(.WIDTH(8)) d84_if ();

    serial_adder #(.WIDTH(8), .CHUNK(1)) u_d81 (.clk_i(clk), .rst_i(rst), .bus(d81_if));
    serial_adder #(.WIDTH(8), .CHUNK(4)) u_d84 (.clk_i(clk), .rst_i(rst), .bus(d84_if));

    assign d81_if.a_i         = a;
    assign d81_if.b_i         = b;
    assign d81_if.sub_i       = sub;
    assign d81_if.carry_i     = cin;
    assign d81_if.in_valid_i  = vld && (sel == 0);
    assign d81_if.out_ready_i = ordy && (sel == 0);
    assign d84_if.a_i         = a;
    assign d84_if.b_i         = b;
    assign d84_if.sub_i       = sub;
    assign d84_if.carry_i     = cin;
    assign d84_if.in_valid_i  = vld && (sel == 1);
    assign d84_if.out_ready_i = ordy && (sel == 1);

    assign rsum   = (sel == 1) ? d84_if.sum_o       : d81_if.sum_o;
    assign rcarry = (sel == 1) ? d84_if.carry_o     : d81_if.carry_o;
    assign rovf   = (sel == 1) ? d84_if.overflow_o  : d81_if.overflow_o;
    assign rvalid = (sel == 1) ? d84_if.out_valid_o : d81_if.out_valid_o;
    assign rready = (sel == 1) ? d84_if.in_ready_o  : d81_if.in_ready_o;

    // Compare one value and report it.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference: plain integer arithmetic on unsigned and signed views.
    function automatic res_t refModel(input int w, input logic [31:0] av, input logic [31:0] bv,
                                      input logic s, input logic c);
        res_t   r;
        longint m, ua, ub, sa, sb, ur, sr;
        m  = longint'(1) << w;
        ua = longint'(av);
        ub = longint'(bv);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (!s) begin
            ur  = ua + ub + longint'(c);
            sr  = sa + sb + longint'(c);
            r.c = (ur >= m);
        end else begin
            ur  = ua - ub - longint'(c);
            sr  = sa - sb - longint'(c);
            r.c = (ur >= 0);
        end
        r.sum = 32'(ur & (m - 1));
        r.v   = (sr > m / 2 - 1) || (sr < -(m / 2));
        return r;
    endfunction

    function automatic logic [31:0] pickOperand(input int w);
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return mask;
            2:       return 32'd1 << (w - 1);
            default: return $urandom & mask;
        endcase
    endfunction

    // Count edges until the selected instance raises out_valid; note any in_ready seen meanwhile.
    task automatic waitDone(input int limit, output int edges, output logic rdy_seen);
        edges    = 0;
        rdy_seen = 1'b0;
        while (edges < limit) begin
            @(posedge clk);
            #1;
            edges++;
            if (rready) rdy_seen = 1'b1;
            if (rvalid) break;
        end
    endtask

    // Drive one vector, accept it, wait for the result and compare; leaves the unit in DONE.
    task automatic applyStimulus(input vec_t v, input string tag);
        int   edges;
        logic rdy_seen;
        @(negedge clk);
        sel = v.sel; a = v.a; b = v.b; sub = v.sub; cin = v.cin; vld = 1'b1;
        #1;
        checkOutput({tag, " in_ready idle"}, 32'(rready), 32'd1);
        @(posedge clk);
        #1;
        vld = 1'b0;
        waitDone(40, edges, rdy_seen);
        checkOutput({tag, " latency"}, 32'(edges), 32'(v.lat));
        checkOutput({tag, " in_ready busy"}, 32'(rdy_seen), 32'd0);
        checkOutput({tag, " sum"}, 32'(rsum), 32'(v.esum));
        checkOutput({tag, " carry"}, 32'(rcarry), 32'(v.ecarry));
        checkOutput({tag, " overflow"}, 32'(rovf), 32'(v.eovf));
    endtask

    // Complete the output handshake and confirm return to IDLE.
    task automatic releaseResult(input string tag);
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
        checkOutput({tag, " out_valid after accept"}, 32'(rvalid), 32'd0);
        checkOutput({tag, " in_ready after accept"}, 32'(rready), 32'd1);
    endtask

    // Random regression instances, each with its own driver, monitor and scoreboard.
    for (genvar g = 0; g < 4; g++) begin : g_rand
        localparam int W = (g == 0) ? 8 : (g == 1) ? 8 : (g == 2) ? 16 : 32;
        localparam int C = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 32;

        serial_adder_if #(.WIDTH(W)) bus ();
        serial_adder #(.WIDTH(W), .CHUNK(C)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

        res_t sb[$];
        logic rand_done = 1'b0;

        initial begin
            int          t;
            logic [31:0] av, bv;
            logic        sv, cv;
            bus.in_valid_i = 1'b0;
            bus.a_i        = '0;
            bus.b_i        = '0;
            bus.sub_i      = 1'b0;
            bus.carry_i    = 1'b0;
            wait (start_random);
            for (int n = 0; n < NOPS; n++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                @(negedge clk);
                av = pickOperand(W);
                bv = pickOperand(W);
                sv = 1'($urandom_range(0, 1));
                cv = 1'($urandom_range(0, 1));
                bus.a_i        = W'(av);
                bus.b_i        = W'(bv);
                bus.sub_i      = sv;
                bus.carry_i    = cv;
                bus.in_valid_i = 1'b1;
                t = 0;
                while (!bus.in_ready_o && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                if (!bus.in_ready_o) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL w%0d/c%0d accept timeout: in_ready 0 expected 1", W, C);
                    break;
                end
                sb.push_back(refModel(W, av, bv, sv, cv));
                @(posedge clk);
                #1;
                bus.in_valid_i = 1'b0;
            end
        end

        initial begin
            int   got, cyc;
            res_t e;
            bus.out_ready_i = 1'b0;
            wait (start_random);
            got = 0;
            cyc = 0;
            while (got < NOPS && cyc < RAND_LIMIT) begin
                @(negedge clk);
                cyc++;
                bus.out_ready_i = ($urandom_range(0, 2) != 0);
                if (bus.out_valid_o && bus.out_ready_i) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL w%0d/c%0d unexpected result: got 0x%0h expected none", W, C, bus.sum_o);
                    end else begin
                        e = sb.pop_front();
                        checkOutput($sformatf("w%0d/c%0d sum", W, C), 32'(bus.sum_o), e.sum);
                        checkOutput($sformatf("w%0d/c%0d carry", W, C), 32'(bus.carry_o), 32'(e.c));
                        checkOutput($sformatf("w%0d/c%0d overflow", W, C), 32'(bus.overflow_o), 32'(e.v));
                    end
                    got++;
                end
            end
            if (got < NOPS) begin
                checks++;
                errors++;
                $display("[TB] FAIL w%0d/c%0d result count: got %0d expected %0d", W, C, got, NOPS);
            end
            @(posedge clk);
            #1;
            bus.out_ready_i = 1'b0;
            rand_done = 1'b1;
        end
    end

    vec_t vecs[10];

    initial begin
        int   edges, cyc;
        logic rdy_seen;

        vecs[0] = '{0, 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, 8};
        vecs[1] = '{0, 8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 8};
        vecs[2] = '{0, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 8};
        vecs[3] = '{1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 2};
        vecs[4] = '{1, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 2};
        vecs[5] = '{0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8};
        vecs[6] = '{0, 8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8};
        vecs[7] = '{1, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 2};
        vecs[8] = '{1, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2};
        vecs[9] = '{1, 8'h23, 8'h45, 1'b1, 1'b1, 8'hDD, 1'b0, 1'b0, 2};

        rst = 1'b1; vld = 1'b0; ordy = 1'b0; sel = 0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", 32'(rready), 32'd1);
        checkOutput("reset out_valid", 32'(rvalid), 32'd0);
        checkOutput("reset sum", 32'(rsum), 32'd0);
        checkOutput("reset carry", 32'(rcarry), 32'd0);
        checkOutput("reset overflow", 32'(rovf), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
            releaseResult($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold and new operands must wait while out_ready is low.
        applyStimulus('{0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 8}, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 8'h01; b = 8'h01; sub = 1'b0; cin = 1'b0; vld = 1'b1;
            #1;
            checkOutput("bp hold out_valid", 32'(rvalid), 32'd1);
            checkOutput("bp hold in_ready", 32'(rready), 32'd0);
            checkOutput("bp hold sum", 32'(rsum), 32'h46);
            checkOutput("bp hold carry", 32'(rcarry), 32'd0);
            checkOutput("bp hold overflow", 32'(rovf), 32'd0);
        end
        @(negedge clk);
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
        checkOutput("bp idle in_ready", 32'(rready), 32'd1);
        checkOutput("bp idle out_valid", 32'(rvalid), 32'd0);
        @(posedge clk);
        #1;
        vld = 1'b0;
        checkOutput("bp new accept", 32'(rready), 32'd0);
        waitDone(40, edges, rdy_seen);
        checkOutput("bp new latency", 32'(edges), 32'd8);
        checkOutput("bp new sum", 32'(rsum), 32'h02);
        releaseResult("bp new");

        // Reset in the middle of an 8-step operation abandons it at once.
        @(negedge clk);
        sel = 0; a = 8'h0F; b = 8'h0F; sub = 1'b0; cin = 1'b0; vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("mid-run busy", 32'(rready), 32'd0);
        checkOutput("mid-run partial sum", 32'(rsum), 32'h06);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async reset out_valid", 32'(rvalid), 32'd0);
        checkOutput("async reset sum", 32'(rsum), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post reset in_ready", 32'(rready), 32'd1);
        applyStimulus('{0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 8}, "post reset");
        releaseResult("post reset");

        start_random = 1'b1;
        cyc = 0;
        while (!(g_rand[0].rand_done && g_rand[1].rand_done &&
                 g_rand[2].rand_done && g_rand[3].rand_done) && cyc < RAND_LIMIT + 5000) begin
            @(negedge clk);
            cyc++;
        end
        if (!(g_rand[0].rand_done && g_rand[1].rand_done &&
              g_rand[2].rand_done && g_rand[3].rand_done)) begin
            checks++;
            errors++;
            $display("[TB] FAIL random regression completion: got incomplete expected complete");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
